// File: rtl/logs_nco_bank_if.sv
// Configuration/step bus and waveform outputs of the multi-channel NCO bank.
// The master drives step and the write port; the slave (the bank) drives
// the registered waveform samples and wrap strobes.
interface logs_nco_bank_if #(
    parameter int N  = 8,
    parameter int CH = 4,
    parameter int W  = 4
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    logic              step;
    logic              wr_en;
    logic [CW-1:0]     wr_ch;
    logic [N-2:0]      wr_freq;
    logic [1:0]        wr_mode;
    logic [W-1:0]      wr_duty;
    logic              wr_restart;
    logic [CH*W-1:0]   wave;
    logic [CH-1:0]     wrap;

    modport master (
        output step, wr_en, wr_ch, wr_freq, wr_mode, wr_duty, wr_restart,
        input  wave, wrap
    );

    modport slave (
        input  step, wr_en, wr_ch, wr_freq, wr_mode, wr_duty, wr_restart,
        output wave, wrap
    );
endinterface

// File: rtl/logs_nco_bank.sv
// Multi-channel numerically-controlled oscillator bank.
// Each channel owns an N-bit phase accumulator plus frequency, waveform mode
// and pulse-duty registers. On a step edge every active channel adds its
// frequency word to its phase, samples the waveform from the phase *before*
// the add (one-step output latency) and reports the accumulator carry as a
// one-clock wrap strobe. All outputs are registered.
module logs_nco_bank #(
    parameter int N  = 8,
    parameter int CH = 4,
    parameter int W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    logs_nco_bank_if.slave   bus
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_PULSE = 2'd1,
        MODE_SAW   = 2'd2,
        MODE_TRI   = 2'd3
    } mode_e;

    logic            wr_ch_ok;
    logic [CH*W-1:0] wave_all;
    logic [CH-1:0]   wrap_all;

    // Writes addressed beyond the last channel are dropped entirely.
    always_comb begin
        wr_ch_ok = bus.wr_en && (int'(bus.wr_ch) < CH);
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [N-1:0] phase_q, phase_d;
        logic [N-2:0] freq_q;
        mode_e        mode_q;
        logic [W-1:0] duty_q;
        logic [W-1:0] wave_q, wave_d;
        logic         wrap_q, wrap_d;

        logic         wr_hit;
        logic [N:0]   sum;
        logic [W-1:0] top;
        logic [W-1:0] tri_bits;
        logic [W-1:0] sample;

        // Accumulator sum and waveform sample of the current (pre-add) phase.
        always_comb begin
            wr_hit   = wr_ch_ok && (bus.wr_ch == CW'(c));
            sum      = {1'b0, phase_q} + {2'b00, freq_q};
            top      = phase_q[N-1 -: W];
            tri_bits = phase_q[N-2 -: W];
            sample   = '0;
            case (mode_q)
                MODE_PULSE: sample = (top < duty_q) ? '1 : '0;
                MODE_SAW:   sample = top;
                MODE_TRI:   sample = phase_q[N-1] ? ~tri_bits : tri_bits;
                default:    sample = '0;
            endcase
        end

        // Next phase/wave/wrap. A restart or a write to mode 0 zeroes the phase
        // on the write edge; the sample still comes from the old settings.
        always_comb begin
            phase_d = phase_q;
            wave_d  = wave_q;
            wrap_d  = 1'b0;
            if (mode_q == MODE_OFF) begin
                phase_d = '0;
                wave_d  = '0;
            end else if (bus.step) begin
                phase_d = sum[N-1:0];
                wrap_d  = sum[N];
                wave_d  = sample;
            end
            if (wr_hit) begin
                if (bus.wr_restart || (mode_e'(bus.wr_mode) == MODE_OFF)) begin
                    phase_d = '0;
                end
                if (bus.wr_restart) begin
                    wrap_d = 1'b0;
                end
            end
        end

        // Channel state registers; configuration loads only on a hit write.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                phase_q <= '0;
                freq_q  <= '0;
                mode_q  <= MODE_OFF;
                duty_q  <= '0;
                wave_q  <= '0;
                wrap_q  <= 1'b0;
            end else begin
                phase_q <= phase_d;
                wave_q  <= wave_d;
                wrap_q  <= wrap_d;
                if (wr_hit) begin
                    freq_q <= bus.wr_freq;
                    mode_q <= mode_e'(bus.wr_mode);
                    duty_q <= bus.wr_duty;
                end
            end
        end

        assign wave_all[c*W +: W] = wave_q;
        assign wrap_all[c]        = wrap_q;
    end

    assign bus.wave = wave_all;
    assign bus.wrap = wrap_all;

endmodule

// File: tb/tb_logs_nco_bank.sv
// Scoreboard bench for logs_nco_bank: the driver computes the expected
// post-edge outputs from an arithmetic channel model and queues them; the
// monitor pops and compares on every falling edge.
module tb_logs_nco_bank;
    localparam int N  = 8;
    localparam int CH = 3;
    localparam int W  = 4;
    localparam int VW = CH*W + CH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logs_nco_bank_if #(.N(N), .CH(CH), .W(W)) bus ();

    logs_nco_bank #(.N(N), .CH(CH), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference channel model: plain integers.
    int ph [CH];
    int fr [CH];
    int md [CH];
    int du [CH];
    int ew [CH];
    int ewr[CH];

    logic [VW-1:0] exp_q[$];

    function automatic int wave_of(int mode, int phase, int duty);
        int top;
        int t;
        top = phase / (1 << (N-W));
        t   = (phase / (1 << (N-1-W))) % (1 << W);
        case (mode)
            1: return (top < duty) ? (1 << W) - 1 : 0;
            2: return top;
            3: return (phase >= (1 << (N-1))) ? (1 << W) - 1 - t : t;
            default: return 0;
        endcase
    endfunction

    task automatic model_clear();
        for (int c = 0; c < CH; c++) begin
            ph[c] = 0; fr[c] = 0; md[c] = 0; du[c] = 0; ew[c] = 0; ewr[c] = 0;
        end
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_edge();
        int np, nw, nwr, s;
        bit hit;
        for (int c = 0; c < CH; c++) begin
            np  = ph[c];
            nw  = ew[c];
            nwr = 0;
            if (md[c] == 0) begin
                np = 0;
                nw = 0;
            end else if (bus.step) begin
                nw  = wave_of(md[c], ph[c], du[c]);
                s   = ph[c] + fr[c];
                nwr = (s >= (1 << N)) ? 1 : 0;
                np  = s % (1 << N);
            end
            hit = bus.wr_en && (int'(bus.wr_ch) == c);
            if (hit) begin
                if (bus.wr_restart) begin
                    np  = 0;
                    nwr = 0;
                end
                if (bus.wr_mode == 2'd0) np = 0;
                fr[c] = int'(bus.wr_freq);
                md[c] = int'(bus.wr_mode);
                du[c] = int'(bus.wr_duty);
            end
            ph[c]  = np;
            ew[c]  = nw;
            ewr[c] = nwr;
        end
    endtask

    task automatic tick();
        logic [VW-1:0] e;
        if (!rst_n) model_clear();
        else model_edge();
        e = '0;
        for (int c = 0; c < CH; c++) begin
            e[CH + c*W +: W] = W'(ew[c]);
            e[c]             = (ewr[c] != 0);
        end
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic randomize_inputs();
        bus.step       = ($urandom_range(0, 3) != 0);
        bus.wr_en      = ($urandom_range(0, 5) == 0);
        bus.wr_ch      = 2'($urandom_range(0, 3));
        bus.wr_freq    = 7'($urandom);
        bus.wr_mode    = 2'($urandom);
        bus.wr_duty    = 4'($urandom);
        bus.wr_restart = ($urandom_range(0, 3) == 0);
    endtask

    task automatic write_ch(input int ch, input int freq, input int mode,
                            input int duty, input bit restart, input bit stp);
        bus.step       = stp;
        bus.wr_en      = 1'b1;
        bus.wr_ch      = 2'(ch);
        bus.wr_freq    = 7'(freq);
        bus.wr_mode    = 2'(mode);
        bus.wr_duty    = 4'(duty);
        bus.wr_restart = restart;
        tick();
        bus.wr_en      = 1'b0;
        bus.wr_restart = 1'b0;
    endtask

    // Assert reset mid-cycle: outputs must clear before any clock edge.
    task automatic mid_reset(input int cycles);
        @(negedge clk);
        #1 rst_n = 1'b0;
        model_clear();
        #1;
        vectors++;
        if (bus.wave !== '0 || bus.wrap !== '0) begin
            miscompares++;
            $display("FAIL async_reset t=%0t wave=%h wrap=%b required wave=0 wrap=0",
                     $time, bus.wave, bus.wrap);
        end
        for (int i = 0; i < cycles; i++) begin
            randomize_inputs();
            tick();
        end
        rst_n = 1'b1;
    endtask

    // Monitor: outputs are presented every cycle, checked on the falling edge.
    logic [VW-1:0] got_v, exp_v;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = {bus.wave, bus.wrap};
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t wave=%h wrap=%b required wave=%h wrap=%b",
                         $time, got_v[VW-1:CH], got_v[CH-1:0], exp_v[VW-1:CH], exp_v[CH-1:0]);
            end
        end
    end

    initial begin
        model_clear();
        randomize_inputs();
        repeat (3) tick();
        #1 rst_n = 1'b1;

        // No configuration yet: everything stays zero under step.
        bus.wr_en = 1'b0; bus.wr_restart = 1'b0; bus.step = 1'b1;
        repeat (8) tick();

        // Sawtooth ch0, pulse ch1 duty 4, triangle ch2.
        write_ch(0, 16, 2, 0, 1'b0, 1'b1);
        write_ch(1, 8, 1, 4, 1'b0, 1'b1);
        write_ch(2, 8, 3, 0, 1'b0, 1'b1);
        bus.step = 1'b1;
        repeat (70) tick();

        // Step gating.
        for (int i = 0; i < 20; i++) begin
            bus.step = i[0];
            tick();
        end

        // Frequency change on a step edge, then restart.
        write_ch(0, 32, 2, 0, 1'b0, 1'b1);
        bus.step = 1'b1;
        repeat (10) tick();
        write_ch(0, 32, 2, 0, 1'b1, 1'b1);
        repeat (10) tick();

        // Out-of-range channel write is ignored.
        for (int i = 0; i < 4; i++) write_ch(3, $urandom_range(0, 127), $urandom_range(0, 3),
                                             $urandom_range(0, 15), i[0], 1'b1);
        repeat (6) tick();

        // Turn ch1 off, then pulse with duty 0, then max duty.
        write_ch(1, 8, 0, 4, 1'b0, 1'b1);
        repeat (6) tick();
        write_ch(1, 8, 1, 0, 1'b0, 1'b1);
        repeat (34) tick();
        write_ch(1, 8, 1, 15, 1'b0, 1'b1);
        repeat (34) tick();

        // Zero frequency in an active mode freezes the phase.
        write_ch(2, 0, 2, 0, 1'b0, 1'b1);
        repeat (6) tick();

        mid_reset(2);
        bus.wr_en = 1'b0; bus.step = 1'b1;
        repeat (6) tick();

        // Randomised run with occasional mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) mid_reset($urandom_range(1, 3));
            randomize_inputs();
            tick();
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain pending=%0d required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
